// File: rtl/scratch_pad_port_adapter_pkg.sv
// Shared types and helpers for the scratch_pad port adapter slice.
//   op_e       : request kind carried in the MSB of a packed request word
//   cnt_width  : width of a counter that must hold 0..depth inclusive
//   req_width  : width of a packed {write, addr, data} request word
package scratch_pad_port_adapter_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/scratch_pad_port_adapter_fifo.sv
// sp_port_fifo: synchronous first-word-fall-through FIFO with count output.
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   wr_en/wr_data push (ignored when full)
//   rd_en         pop (ignored when empty); rd_data shows the head word
//   empty/full    status, count = number of stored words
module sp_port_fifo
    import scratch_pad_port_adapter_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [W-1:0]                  wr_data,
    input  logic                          rd_en,
    output logic [W-1:0]                  rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int IW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [IW:0]  wr_ptr;
    logic [IW:0]  rd_ptr;
    logic         do_wr;
    logic         do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the index bits match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; only words behind the write pointer are ever read.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[IW-1:0]] <= wr_data;
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[IW-1:0]];

endmodule

// File: rtl/scratch_pad_port_adapter.sv
// scratch_pad_port_adapter: client-side adapter for one scratch_pad port.
// Turns an engine valid/ready request stream into registered scratch_pad
// strobes, and gathers in-order read data into a response FIFO. Reads are
// only issued while a response slot is guaranteed, so the response FIFO
// cannot overflow.
// Ports:
//   clk, rst                         clock; asynchronous active-low reset
//   req_valid/req_ready/req_write/req_addr/req_data   engine request stream
//   sp_rd_en/sp_wr_en/sp_addr/sp_d   registered scratch_pad command
//   sp_full                          scratch_pad cannot take a command now
//   sp_q/sp_valid                    scratch_pad read return
//   sp_stall                         response FIFO full (backstop)
//   resp_valid/resp_ready/resp_data  FWFT response stream to the engine
//   outstanding                      reads issued but not yet returned
//   idle                             nothing queued, in flight or buffered
//   err                              sticky: read data with no read in flight
module scratch_pad_port_adapter
    import scratch_pad_port_adapter_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int REQ_DEPTH  = 4,
    parameter int RESP_DEPTH = 32,
    parameter int CNT_BITS   = cnt_width(RESP_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_data,
    output logic                  sp_rd_en,
    output logic                  sp_wr_en,
    output logic [ADDR_WIDTH-1:0] sp_addr,
    output logic [WIDTH-1:0]      sp_d,
    input  logic                  sp_full,
    input  logic [WIDTH-1:0]      sp_q,
    input  logic                  sp_valid,
    output logic                  sp_stall,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic [CNT_BITS-1:0]   outstanding,
    output logic                  idle,
    output logic                  err
);

    localparam int REQ_W   = req_width(ADDR_WIDTH, WIDTH);
    localparam int REQ_CW  = cnt_width(REQ_DEPTH);
    localparam int RESP_CW = cnt_width(RESP_DEPTH);

    logic [REQ_W-1:0]      req_head;
    logic                  req_empty;
    logic                  req_full;
    logic [REQ_CW-1:0]     req_count;
    logic                  req_push;

    logic                  resp_empty;
    logic                  resp_full;
    logic [RESP_CW-1:0]    resp_count;
    logic                  resp_pop;

    op_e                   head_op;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [WIDTH-1:0]      head_data;
    logic [CNT_BITS:0]     in_use;
    logic                  has_credit;
    logic                  issue;
    logic                  issue_read;
    logic                  capture;

    // Ready is held low while reset is asserted even though the FIFO is empty.
    assign req_ready = rst && !req_full;
    assign req_push  = req_valid && req_ready;

    sp_port_fifo #(.W(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (req_push),
        .wr_data ({req_write, req_addr, req_data}),
        .rd_en   (issue),
        .rd_data (req_head),
        .empty   (req_empty),
        .full    (req_full),
        .count   (req_count)
    );

    assign head_op   = op_e'(req_head[REQ_W-1]);
    assign head_addr = req_head[REQ_W-2 -: ADDR_WIDTH];
    assign head_data = req_head[WIDTH-1:0];

    // A read needs a response slot that is neither buffered nor already
    // promised to an earlier read still in flight.
    assign in_use     = {1'b0, outstanding} + (CNT_BITS+1)'(resp_count);
    assign has_credit = in_use < (CNT_BITS+1)'(RESP_DEPTH);

    // Strictly in-order issue: a credit-starved read also holds back any
    // writes queued behind it.
    always_comb begin
        issue = 1'b0;
        if (!req_empty && !sp_full) begin
            issue = (head_op == OP_WRITE) || has_credit;
        end
    end

    assign issue_read = issue && (head_op == OP_READ);

    // Registered command towards the scratch_pad; strobes are single-cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_rd_en <= 1'b0;
            sp_wr_en <= 1'b0;
            sp_addr  <= '0;
            sp_d     <= '0;
        end else begin
            sp_rd_en <= issue_read;
            sp_wr_en <= issue && (head_op == OP_WRITE);
            if (issue) begin
                sp_addr <= head_addr;
                sp_d    <= head_data;
            end
        end
    end

    // Return data with no read in flight is dropped and flagged instead.
    assign capture  = sp_valid && !sp_stall && (outstanding != '0);
    assign sp_stall = resp_full;
    assign resp_pop = resp_valid && resp_ready;

    sp_port_fifo #(.W(WIDTH), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data (sp_q),
        .rd_en   (resp_pop),
        .rd_data (resp_data),
        .empty   (resp_empty),
        .full    (resp_full),
        .count   (resp_count)
    );

    assign resp_valid = !resp_empty;

    // Simultaneous issue and capture cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
        end else begin
            case ({issue_read, capture})
                2'b10:   outstanding <= outstanding + CNT_BITS'(1);
                2'b01:   outstanding <= outstanding - CNT_BITS'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (sp_valid && (outstanding == '0)) begin
            err <= 1'b1;
        end
    end

    assign idle = (req_count == '0) && (outstanding == '0) && resp_empty;

endmodule
